// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 raster timing generator and frame-buffer reader.
// The horizontal/vertical counters walk the full 800x525 raster. Two pipeline
// stages advance only on pix_ce. Stage 1 issues the RAM read and captures the
// blanking and sync flags for the same position. Stage 2 registers the returned
// colour together with those flags, so RGB and the sync edges leave the block
// aligned.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_data,
    output logic              vga_r,
    output logic              vga_g,
    output logic              vga_b,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One extra code point so that a sync region ending exactly at the
    // line/frame end still has a representable end value.
    localparam int H_W     = $clog2(H_TOTAL + 1);
    localparam int V_W     = $clog2(V_TOTAL + 1);

    localparam logic [H_W-1:0]    H_ZERO_C   = {H_W{1'b0}};
    localparam logic [H_W-1:0]    H_ONE_C    = {{(H_W-1){1'b0}}, 1'b1};
    localparam logic [H_W-1:0]    H_ACT_C    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]    H_LAST_C   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]    HS_START_C = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]    HS_END_C   = H_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [V_W-1:0]    V_ZERO_C   = {V_W{1'b0}};
    localparam logic [V_W-1:0]    V_ONE_C    = {{(V_W-1){1'b0}}, 1'b1};
    localparam logic [V_W-1:0]    V_ACT_C    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]    V_LAST_C   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]    VS_START_C = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]    VS_END_C   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [ADDR_W-1:0] A_ZERO_C   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] A_ONE_C    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_LAST_C   = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    // Raster position and linear read pointer.
    logic [H_W-1:0]    h_cnt_r;
    logic [V_W-1:0]    v_cnt_r;
    logic [ADDR_W-1:0] addr_cnt_r;

    // Stage 1: read request plus flags describing the requested pixel.
    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              frame_start_r;
    logic              act1_r;
    logic              hs1_r;
    logic              vs1_r;

    // Stage 2: what the connector sees.
    logic [2:0]        rgb_r;
    logic              hsync_r;
    logic              vsync_r;

    // Combinational decode of the current position.
    logic [H_W-1:0]    h_nxt_s;
    logic [V_W-1:0]    v_nxt_s;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic              visible_s;
    logic              hs_region_s;
    logic              vs_region_s;
    logic              first_pix_s;
    logic              frame_wrap_s;
    logic [2:0]        rgb_nxt_s;

    // Position decode, counter successors and the colour gate for stage 2.
    always_comb begin
        h_nxt_s      = h_cnt_r;
        v_nxt_s      = v_cnt_r;
        addr_nxt_s   = addr_cnt_r;
        rgb_nxt_s    = 3'b000;

        visible_s    = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
        hs_region_s  = (h_cnt_r >= HS_START_C) && (h_cnt_r < HS_END_C);
        vs_region_s  = (v_cnt_r >= VS_START_C) && (v_cnt_r < VS_END_C);
        first_pix_s  = (h_cnt_r == H_ZERO_C) && (v_cnt_r == V_ZERO_C);
        frame_wrap_s = (h_cnt_r == H_LAST_C) && (v_cnt_r == V_LAST_C);

        if (h_cnt_r == H_LAST_C) begin
            h_nxt_s = H_ZERO_C;
            if (v_cnt_r == V_LAST_C) begin
                v_nxt_s = V_ZERO_C;
            end else begin
                v_nxt_s = v_cnt_r + V_ONE_C;
            end
        end else begin
            h_nxt_s = h_cnt_r + H_ONE_C;
        end

        // The pointer only moves on visible pixels, so the row-major
        // address falls out without a multiplier. After the last pixel of
        // the frame it returns to zero so it never passes A_LAST_C.
        if (visible_s) begin
            if (addr_cnt_r == A_LAST_C) begin
                addr_nxt_s = A_ZERO_C;
            end else begin
                addr_nxt_s = addr_cnt_r + A_ONE_C;
            end
        end else if (frame_wrap_s) begin
            addr_nxt_s = A_ZERO_C;
        end else begin
            addr_nxt_s = addr_cnt_r;
        end

        if (act1_r) begin
            rgb_nxt_s = rd_data;
        end else begin
            rgb_nxt_s = 3'b000;
        end
    end

    // Raster counters and read pointer, advanced once per pixel enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_r    <= H_ZERO_C;
            v_cnt_r    <= V_ZERO_C;
            addr_cnt_r <= A_ZERO_C;
        end else if (pix_ce) begin
            h_cnt_r    <= h_nxt_s;
            v_cnt_r    <= v_nxt_s;
            addr_cnt_r <= addr_nxt_s;
        end
    end

    // Stage 1: issue the read; strobes are one clk wide, address and flags hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_r       <= 1'b0;
            rd_addr_r     <= A_ZERO_C;
            frame_start_r <= 1'b0;
            act1_r        <= 1'b0;
            hs1_r         <= 1'b0;
            vs1_r         <= 1'b0;
        end else if (pix_ce) begin
            rd_en_r       <= visible_s;
            rd_addr_r     <= addr_cnt_r;
            frame_start_r <= visible_s && first_pix_s;
            act1_r        <= visible_s;
            hs1_r         <= hs_region_s;
            vs1_r         <= vs_region_s;
        end else begin
            rd_en_r       <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

    // Stage 2: capture RAM data with the matching blanking and sync flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_r   <= 3'b000;
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
        end else if (pix_ce) begin
            rgb_r   <= rgb_nxt_s;
            hsync_r <= ~hs1_r;
            vsync_r <= ~vs1_r;
        end
    end

    assign rd_en       = rd_en_r;
    assign rd_addr     = rd_addr_r;
    assign frame_start = frame_start_r;
    assign vga_r       = rgb_r[2];
    assign vga_g       = rgb_r[1];
    assign vga_b       = rgb_r[0];
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;

endmodule
